// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//   Read-side drain stage for the async FIFO (r_clk domain). Pops the FIFO
//   read port (1-cycle registered read latency) whenever the 2-entry output
//   buffer can absorb the returning word, and re-presents the data as a
//   valid/ready stream framed into packets of PKT_LEN beats.
//
//   Optional build macro: FIFO_RD_STREAM_STAT_EN
//     Adds beat_total (handshake count, wraps) and stall_cnt (cycles with
//     m_valid & !m_ready, saturating). Both clear on r_rst or flush.
//
// Ports
//   r_clk        read-domain clock
//   r_rst        asynchronous active-high reset
//   enable       1 = allowed to issue new FIFO pops
//   flush        synchronous clear of buffer, in-flight pop and beat counter
//   empty        FIFO empty flag
//   read_data    FIFO read data, valid the cycle after an accepted pop
//   read_enable  FIFO pop strobe (combinational)
//   m_valid      output beat valid
//   m_data       output beat data
//   m_last       last beat of packet
//   m_ready      downstream ready
//   beat_total   (STAT_EN only) handshakes since clear, wraps at 16 bits
//   stall_cnt    (STAT_EN only) stalled cycles since clear, saturates
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 16
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              enable,
  input  logic              flush,
  input  logic              empty,
  input  logic [DATA_W-1:0] read_data,
  output logic              read_enable,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
`ifdef FIFO_RD_STREAM_STAT_EN
  ,
  output logic [15:0]       beat_total,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int               CNT_W     = $clog2(PKT_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic [1:0]        occ;
  logic              inflight;
  logic [CNT_W-1:0]  beat_cnt;
  logic              hs;
  logic [2:0]        level;
  logic              pop;

  // A pop is only issued if the word returning next cycle is guaranteed a
  // slot: buffered + in-flight words, less the one leaving now, must be < 2.
  always_comb begin
    hs    = m_valid & m_ready;
    level = {1'b0, occ} + {2'b00, inflight};
    pop   = enable & ~empty & ~flush & ~r_rst & (level < (3'd2 + {2'b00, hs}));
  end

  assign read_enable = pop;
  assign m_valid     = (occ != 2'd0);
  assign m_data      = head_q;
  assign m_last      = m_valid & (beat_cnt == LAST_BEAT);

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      occ      <= '0;
      inflight <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
      beat_cnt <= '0;
    end else if (flush) begin
      // Clearing inflight drops the word returning from last cycle's pop.
      occ      <= '0;
      inflight <= 1'b0;
      beat_cnt <= '0;
    end else begin
      inflight <= pop;
      case ({inflight, hs})
        2'b10: begin
          if (occ == 2'd0) head_q <= read_data;
          else             tail_q <= read_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          // Simultaneous read and write: occupancy unchanged, order kept.
          if (occ == 2'd1) begin
            head_q <= read_data;
          end else begin
            head_q <= tail_q;
            tail_q <= read_data;
          end
        end
        default: ;
      endcase
      if (hs) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
    end
  end

`ifdef FIFO_RD_STREAM_STAT_EN
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      beat_total <= '0;
      stall_cnt  <= '0;
    end else if (flush) begin
      beat_total <= '0;
      stall_cnt  <= '0;
    end else begin
      if (hs) beat_total <= beat_total + 16'd1;
      if (m_valid && !m_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  occ_bound: assert property (@(posedge r_clk) disable iff (r_rst) occ <= 2'd2);
  no_overwrite: assert property (@(posedge r_clk) disable iff (r_rst)
                                 (inflight && !hs && !flush) |-> (occ < 2'd2));

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  localparam int DATA_W  = 8;
  localparam int PKT_LEN = 16;

  logic              r_clk = 1'b0;
  logic              r_rst;
  logic              enable;
  logic              flush;
  logic              empty = 1'b1;
  logic [DATA_W-1:0] read_data = '0;
  logic              read_enable;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;
`ifdef FIFO_RD_STREAM_STAT_EN
  logic [15:0]       beat_total;
  logic [15:0]       stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Source FIFO contents and the scoreboard of words owed to the output.
  logic [DATA_W-1:0] src_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic              gap = 1'b0;
  logic              pop_hold = 1'b0;
  logic [DATA_W-1:0] pop_data = '0;
  int                beat_idx = 0;
  logic [15:0]       mdl_total = '0;
  logic [15:0]       mdl_stall = '0;

  fifo_rd_stream #(.DATA_W(DATA_W), .PKT_LEN(PKT_LEN)) dut (
    .r_clk       (r_clk),
    .r_rst       (r_rst),
    .enable      (enable),
    .flush       (flush),
    .empty       (empty),
    .read_data   (read_data),
    .read_enable (read_enable),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_ready     (m_ready)
`ifdef FIFO_RD_STREAM_STAT_EN
    ,
    .beat_total  (beat_total),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 r_clk = ~r_clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // FIFO model: a pop seen during the cycle returns its word after the next edge.
  always begin
    @(negedge r_clk);
    #1;
    if (read_enable) begin
      chk("pop_while_empty", 32'(empty), 32'd0);
      if (src_q.size() != 0) begin
        pop_data = src_q.pop_front();
        pop_hold = 1'b1;
        exp_q.push_back(pop_data);
      end
    end
  end

  always @(posedge r_clk) begin
    if (pop_hold) read_data <= pop_data;
    pop_hold = 1'b0;
    empty <= gap || (src_q.size() == 0);
  end

  // Monitor: whatever is presented must be the oldest owed word, framed by
  // its position in the handshake sequence.
  always @(negedge r_clk) begin
    if (r_rst) begin
      exp_q.delete();
      beat_idx  = 0;
      mdl_total = '0;
      mdl_stall = '0;
    end else begin
`ifdef FIFO_RD_STREAM_STAT_EN
      chk("beat_total", 32'(beat_total), 32'(mdl_total));
      chk("stall_cnt", 32'(stall_cnt), 32'(mdl_stall));
`endif
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'(m_valid), 32'd0);
        end else begin
          chk("m_data", 32'(m_data), 32'(exp_q[0]));
          chk("m_last", 32'(m_last), 32'(beat_idx == PKT_LEN - 1));
          if (m_ready) begin
            void'(exp_q.pop_front());
            beat_idx = (beat_idx + 1) % PKT_LEN;
          end
        end
      end else begin
        chk("m_last_idle", 32'(m_last), 32'd0);
      end
      if (flush) begin
        exp_q.delete();
        beat_idx  = 0;
        mdl_total = '0;
        mdl_stall = '0;
      end else begin
        if (m_valid && m_ready) mdl_total = mdl_total + 16'd1;
        if (m_valid && !m_ready && mdl_stall != 16'hFFFF) mdl_stall = mdl_stall + 16'd1;
      end
    end
  end

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(DATA_W'($urandom));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    flush = 1'b0; gap = 1'b0; enable = 1'b1; m_ready = 1'b1;
    while ((src_q.size() != 0 || exp_q.size() != 0 || m_valid) && n < 400) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, 32'(n < 400), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    int stalls;
    r_rst = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
    #1;
    chk("rst_read_enable", 32'(read_enable), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    repeat (3) tick();
    r_rst = 1'b0;

    // Preloaded 0x01..0x20 streams out one beat per cycle.
    for (int i = 1; i <= 32; i++) src_q.push_back(DATA_W'(i));
    tick(); tick();
    enable = 1'b1; m_ready = 1'b1;
    n = 0;
    while (!m_valid && n < 10) begin tick(); n++; end
    chk("t1_start", 32'(n < 10), 32'd1);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge r_clk);
      if (m_valid && m_ready) cnt++;
    end
    chk("t1_throughput", 32'(cnt), 32'd32);
    drain("t1");

    // Alternating backpressure.
    push_rand(16);
    for (int i = 0; i < 40; i++) begin
      m_ready = (i % 2) == 0;
      tick();
    end
    drain("t2");

    // Source runs dry after 5 beats, refills later.
    push_rand(5);
    repeat (12) tick();
    chk("t3_idle_valid", 32'(m_valid), 32'd0);
    push_rand(11);
    drain("t3");

    // Flush while a word is buffered and another is returning.
    push_rand(8);
    enable = 1'b1; m_ready = 1'b0;
    repeat (6) tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_flush_valid", 32'(m_valid), 32'd0);
    push_rand(11);
    drain("t4");

    // Asynchronous reset in the middle of a packet.
    push_rand(20);
    enable = 1'b1; m_ready = 1'b1;
    n = 0;
    while (beat_idx != 7 && n < 60) begin tick(); n++; end
    chk("t5_reach_beat7", 32'(n < 60), 32'd1);
    #2;
    r_rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(m_valid), 32'd0);
    chk("t5_rst_data", 32'(m_data), 32'd0);
    chk("t5_rst_last", 32'(m_last), 32'd0);
    chk("t5_rst_read_enable", 32'(read_enable), 32'd0);
    @(posedge r_clk); @(posedge r_clk);
    #1;
    r_rst = 1'b0;
    drain("t5");

    // Randomized traffic with enable, gaps, backpressure and flushes.
    for (int i = 0; i < 1500; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 7) != 0);
      gap     = ($urandom_range(0, 5) == 0);
      flush   = ($urandom_range(0, 59) == 0);
      if (($urandom_range(0, 1) == 1) && src_q.size() < 40) push_rand(1);
      tick();
    end
    drain("t_rand");

`ifdef FIFO_RD_STREAM_STAT_EN
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push_rand(40);
    enable = 1'b1;
    stalls = 0;
    n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0 || m_valid) && n < 400) begin
      if (m_valid && stalls < 10 && (n % 3) == 0) begin
        m_ready = 1'b0;
        stalls++;
      end else begin
        m_ready = 1'b1;
      end
      tick();
      n++;
    end
    chk("t6_done", 32'(n < 400), 32'd1);
    chk("t6_beat_total", 32'(beat_total), 32'd40);
    chk("t6_stall_cnt", 32'(stall_cnt), 32'd10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_flush_total", 32'(beat_total), 32'd0);
    chk("t6_flush_stall", 32'(stall_cnt), 32'd0);
`else
    stalls = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
